// File: rtl/text_ctrl_pkg.sv
// Shared definitions for the TextBlock character RAM writer.
// Contents:
//   op_e         - command op codes (2'b11 is treated like NOP)
//   state_e      - controller FSM states
//   CHAR_*       - ASCII constants used when building RAM words
//   format_field - turns 5 BCD digits into the 8-char right-aligned field
package text_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_CLEAR = 2'b01,
        OP_PRINT = 2'b10
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        CONV,
        WR0,
        WR1,
        FIN
    } state_e;

    localparam logic [7:0]  CHAR_SPACE  = 8'h20;
    localparam logic [7:0]  CHAR_ZERO   = 8'h30;
    localparam int          FIELD_CHARS = 8;
    localparam int          CONV_CYCLES = 16;
    localparam logic [31:0] SPACE_WORD  = {4{CHAR_SPACE}};

    // Char i of the field sits in bits [8i+7:8i], so bits [31:0] are the
    // first RAM word and [63:32] the second. Three leading pad spaces,
    // then the digits from ten-thousands down to units; zeros before the
    // first non-zero digit are blanked, the units digit never is.
    function automatic logic [8*FIELD_CHARS-1:0] format_field(input logic [19:0] bcd);
        logic [8*FIELD_CHARS-1:0] field;
        logic                     leading;
        logic [3:0]               digit;
        field   = {FIELD_CHARS{CHAR_SPACE}};
        leading = 1'b1;
        for (int k = 0; k < 5; k++) begin
            digit = bcd[4*(4-k) +: 4];
            if (leading && digit == 4'd0 && k != 4) begin
                field[8*(3+k) +: 8] = CHAR_SPACE;
            end else begin
                leading             = 1'b0;
                field[8*(3+k) +: 8] = CHAR_ZERO + {4'd0, digit};
            end
        end
        return field;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to 5-digit BCD converter (double dabble).
// Ports:
//   clk, rst_n - clock, synchronous active-low reset
//   start      - pulse with value valid; loads the converter
//   value      - 16-bit unsigned input
//   done       - one-cycle pulse after the last iteration
//   bcd        - 5 BCD digits, [19:16] most significant; stable until next start
// One iteration per clock, so done follows start by CONV_CYCLES edges.
module bin2bcd_seq
    import text_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] value,
    output logic        done,
    output logic [19:0] bcd
);

    logic [15:0] bin_q;
    logic [3:0]  iter_q;
    logic        running_q;
    logic [19:0] adjusted;

    // Add-3 correction on every digit that would overflow past 9 when doubled.
    always_comb begin
        adjusted = bcd;
        for (int d = 0; d < 5; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                adjusted[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q     <= '0;
            iter_q    <= '0;
            running_q <= 1'b0;
            done      <= 1'b0;
            bcd       <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                bin_q     <= value;
                bcd       <= '0;
                iter_q    <= '0;
                running_q <= 1'b1;
            end else if (running_q) begin
                bcd    <= {adjusted[18:0], bin_q[15]};
                bin_q  <= {bin_q[14:0], 1'b0};
                iter_q <= iter_q + 4'd1;
                if (iter_q == 4'(CONV_CYCLES - 1)) begin
                    running_q <= 1'b0;
                    done      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/text_ram_ctrl.sv
// Command-driven writer for the TextBlock character RAM write port.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   cmd_valid/cmd_ready - command handshake (accepted when both high)
//   cmd_op              - 01 CLEAR screen to spaces, 10 PRINT value, else NOP
//   cmd_addr            - PRINT: word address of the field's first word
//   cmd_value           - PRINT: 16-bit unsigned value
//   busy                - command in progress
//   done                - one-cycle pulse when a command completes
//   we, wa, wdata       - RAM write port (4 chars per word, byte k = column k)
// All outputs are registers loaded with the values chosen for the state
// being entered, so e.g. entering WR0 is the cycle word 0 is on the bus.
module text_ram_ctrl
    import text_ctrl_pkg::*;
#(
    parameter  int TEXT_WIDTH  = 16,
    parameter  int TEXT_HEIGHT = 16,
    localparam int WA_W        = $clog2(TEXT_WIDTH) + $clog2(TEXT_HEIGHT) - 2
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [WA_W-1:0] cmd_addr,
    input  logic [15:0]     cmd_value,
    output logic            busy,
    output logic            done,
    output logic            we,
    output logic [WA_W-1:0] wa,
    output logic [31:0]     wdata
);

    localparam int NWORDS = TEXT_WIDTH * TEXT_HEIGHT / 4;

    state_e                 state_q, state_d;
    logic   [WA_W:0]        cnt_q, cnt_d;
    logic   [WA_W-1:0]      addr_q, addr_d;
    logic                   ready_d, busy_d, done_d, we_d;
    logic   [WA_W-1:0]      wa_d;
    logic   [31:0]          wdata_d;
    logic                   bcd_start, bcd_done;
    logic   [19:0]          bcd;
    logic   [63:0]          field;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (bcd_start),
        .value (cmd_value),
        .done  (bcd_done),
        .bcd   (bcd)
    );

    assign field = format_field(bcd);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            we        <= 1'b0;
            wa        <= '0;
            wdata     <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            cmd_ready <= ready_d;
            busy      <= busy_d;
            done      <= done_d;
            we        <= we_d;
            wa        <= wa_d;
            wdata     <= wdata_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
        end
    end

    // FIN accepts commands exactly like IDLE so back-to-back commands lose
    // no cycle. A NOP passes through WR1, which only ever finishes, giving
    // the single busy cycle before its done pulse without a write.
    always_comb begin
        state_d   = state_q;
        ready_d   = cmd_ready;
        busy_d    = busy;
        done_d    = 1'b0;
        we_d      = 1'b0;
        wa_d      = wa;
        wdata_d   = wdata;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        bcd_start = 1'b0;
        case (state_q)
            IDLE, FIN: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
                if (cmd_valid && cmd_ready) begin
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    addr_d  = cmd_addr;
                    case (op_e'(cmd_op))
                        OP_CLEAR: begin
                            state_d = CLEAR;
                            cnt_d   = '0;
                        end
                        OP_PRINT: begin
                            state_d   = CONV;
                            bcd_start = 1'b1;
                        end
                        default: state_d = WR1;
                    endcase
                end
            end
            CLEAR: begin
                if (cnt_q == (WA_W+1)'(NWORDS)) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    we_d    = 1'b1;
                    wa_d    = cnt_q[WA_W-1:0];
                    wdata_d = SPACE_WORD;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            CONV: begin
                if (bcd_done) begin
                    state_d = WR0;
                    we_d    = 1'b1;
                    wa_d    = addr_q;
                    wdata_d = field[31:0];
                end
            end
            WR0: begin
                // Word address arithmetic wraps at NWORDS since NWORDS = 2**WA_W.
                state_d = WR1;
                we_d    = 1'b1;
                wa_d    = addr_q + 1'b1;
                wdata_d = field[63:32];
            end
            WR1: begin
                state_d = FIN;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_text_ram_ctrl.sv
// Directed self-checking bench for text_ram_ctrl (16x16 text, 64 words).
// Outputs are sampled 1 ns after each rising edge.
module tb_text_ram_ctrl;

    localparam int WA_W = 6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [WA_W-1:0] cmd_addr;
    logic [15:0]     cmd_value;
    logic            busy;
    logic            done;
    logic            we;
    logic [WA_W-1:0] wa;
    logic [31:0]     wdata;

    int checks   = 0;
    int failures = 0;

    text_ram_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_value (cmd_value),
        .busy      (busy),
        .done      (done),
        .we        (we),
        .wa        (wa),
        .wdata     (wdata)
    );

    always #5 clk = ~clk;

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] op,
                                 input logic [WA_W-1:0] addr, input logic [15:0] value);
        cmd_valid = v;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_value = value;
    endtask

    task automatic waitReady();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin
            stepEdge();
            n++;
        end
        checkOutput("wait_ready", cmd_ready, 1);
    endtask

    // One PRINT command; with hold set, cmd_valid stays high (with junk
    // payload) for the whole command to show nothing extra is accepted.
    task automatic runPrint(input string tag, input logic [WA_W-1:0] addr, input logic [15:0] value,
                            input logic [31:0] exp0, input logic [WA_W-1:0] expWa1,
                            input logic [31:0] exp1, input logic hold);
        int noisy = 0;
        waitReady();
        applyStimulus(1'b1, 2'b10, addr, value);
        stepEdge();
        if (hold) applyStimulus(1'b1, 2'b01, ~addr, ~value);
        else      applyStimulus(1'b0, 2'b00, '0, '0);
        checkOutput({tag, "_accept"}, {busy, cmd_ready, we}, 3'b100);
        for (int k = 1; k <= 16; k++) begin
            stepEdge();
            if (we !== 1'b0 || done !== 1'b0 || busy !== 1'b1) noisy++;
        end
        checkOutput({tag, "_conv_quiet"}, noisy, 0);
        stepEdge();
        checkOutput({tag, "_w0_we"}, we, 1);
        checkOutput({tag, "_w0_wa"}, wa, addr);
        checkOutput({tag, "_w0_data"}, wdata, exp0);
        stepEdge();
        checkOutput({tag, "_w1_we"}, we, 1);
        checkOutput({tag, "_w1_wa"}, wa, expWa1);
        checkOutput({tag, "_w1_data"}, wdata, exp1);
        stepEdge();
        checkOutput({tag, "_fin"}, {we, done, cmd_ready, busy}, 4'b0110);
        applyStimulus(1'b0, 2'b00, '0, '0);
        stepEdge();
        checkOutput({tag, "_after"}, {we, done, cmd_ready, busy}, 4'b0010);
    endtask

    initial begin
        int bad;
        rst_n = 1'b0;
        applyStimulus(1'b0, 2'b00, '0, '0);
        repeat (3) stepEdge();
        checkOutput("reset_ready", cmd_ready, 0);
        checkOutput("reset_flags", {busy, done, we}, 3'b000);
        checkOutput("reset_wa", wa, 0);
        checkOutput("reset_wdata", wdata, 32'h0);

        rst_n = 1'b1;
        stepEdge();
        checkOutput("ready_after_reset", cmd_ready, 1);
        checkOutput("idle_flags", {busy, done, we}, 3'b000);

        // Full-screen clear: 64 writes of spaces, then done.
        applyStimulus(1'b1, 2'b01, '0, '0);
        stepEdge();
        applyStimulus(1'b0, 2'b00, '0, '0);
        checkOutput("clear_accept", {busy, cmd_ready, we}, 3'b100);
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            stepEdge();
            if (we !== 1'b1 || wa !== WA_W'(k) || wdata !== 32'h20202020 || done !== 1'b0) bad++;
        end
        checkOutput("clear_bad_words", bad, 0);
        stepEdge();
        checkOutput("clear_fin", {we, done, cmd_ready, busy}, 4'b0110);
        stepEdge();
        checkOutput("clear_after", {we, done, cmd_ready, busy}, 4'b0010);

        runPrint("p1234", 6'd5, 16'd1234, 32'h20202020, 6'd6, 32'h34333231, 1'b0);
        runPrint("p0", 6'd0, 16'd0, 32'h20202020, 6'd1, 32'h30202020, 1'b0);
        runPrint("p65535", 6'd10, 16'd65535, 32'h36202020, 6'd11, 32'h35333535, 1'b0);
        runPrint("p10007", 6'd20, 16'd10007, 32'h31202020, 6'd21, 32'h37303030, 1'b0);
        runPrint("p405", 6'd33, 16'd405, 32'h20202020, 6'd34, 32'h35303420, 1'b0);
        runPrint("pwrap", 6'd63, 16'd7, 32'h20202020, 6'd0, 32'h37202020, 1'b1);

        // Reset in the middle of a clear, then a NOP.
        waitReady();
        applyStimulus(1'b1, 2'b01, '0, '0);
        stepEdge();
        applyStimulus(1'b0, 2'b00, '0, '0);
        repeat (10) stepEdge();
        checkOutput("midclear_wa", {we, wa}, {1'b1, 6'd9});
        rst_n = 1'b0;
        stepEdge();
        checkOutput("abort_flags", {we, busy, done, cmd_ready}, 4'b0000);
        rst_n = 1'b1;
        stepEdge();
        checkOutput("abort_recover", {we, busy, done, cmd_ready}, 4'b0001);
        applyStimulus(1'b1, 2'b00, '0, '0);
        stepEdge();
        applyStimulus(1'b0, 2'b00, '0, '0);
        checkOutput("nop_accept", {we, busy, done, cmd_ready}, 4'b0100);
        stepEdge();
        checkOutput("nop_fin", {we, busy, done, cmd_ready}, 4'b0011);
        stepEdge();
        checkOutput("nop_after", {we, busy, done, cmd_ready}, 4'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
